// File: rtl/dsp_pkg.sv
// Shared definitions for the W-channel order dispatcher: order-entry layout,
// FSM state encoding and queue width derivations.
package dsp_pkg;

  localparam int OUTST_DEPTH_DEF = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // order queue empty, W stalled
  localparam logic [1:0] ST_FWD  = 2'd1;  // head routes beats to a slave lane
  localparam logic [1:0] ST_SINK = 2'd2;  // head is a decode error, beats dropped

  // Order entry is {decerr, slv_id}: slv_id in the low bits, decerr on top.
  function automatic int ent_w(input int id_w);
    return id_w + 1;
  endfunction

  function automatic int ent_decerr_bit(input int id_w);
    return id_w;
  endfunction

  // Occupancy counter must hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dsp_order_fifo.sv
// AW order queue. Besides the usual full/count it exposes the head that will
// be current after this cycle's push/pop, so the consumer can register its
// head selection without a dead cycle after each pop.
module dsp_order_fifo
  import dsp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = 3,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [EW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic [CW-1:0] o_cnt,
  output logic          o_empty_nxt,
  output logic [EW-1:0] o_head_nxt
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_push;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign w_push    = i_push & ~o_full;
  assign w_rd_nxt  = r_rd + PW'(i_pop);
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(i_pop);
  assign o_cnt     = r_cnt;
  assign o_empty_nxt = (w_cnt_nxt == '0);
  // Pushed entry becomes head when it lands on the next read slot (queue was
  // empty, or held only the entry being popped).
  assign o_head_nxt = (w_push && (r_wr == w_rd_nxt)) ? i_data : r_mem[w_rd_nxt];

  // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Entry storage, no reset needed: validity is tracked by the counter
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/skid_buffer.sv
// Fully registered skid buffer: both output and upstream ready come straight
// from flops, one beat per cycle sustained, payload stable while stalled.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_out_v;
  logic [W-1:0] r_out_d;
  logic         r_skid_v;
  logic [W-1:0] r_skid_d;

  assign o_ready = ~r_skid_v;
  assign o_valid = r_out_v;
  assign o_data  = r_out_d;

  // Output register refills from the skid first, else from the input; a beat
  // arriving while the output is stalled parks in the skid register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_v  <= 1'b0;
      r_out_d  <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (i_ready || !r_out_v) begin
      if (r_skid_v) begin
        r_out_v  <= 1'b1;
        r_out_d  <= r_skid_d;
        r_skid_v <= 1'b0;
      end else begin
        r_out_v <= i_valid;
        if (i_valid) r_out_d <= i_data;
      end
    end else if (i_valid && !r_skid_v) begin
      r_skid_v <= 1'b1;
      r_skid_d <= i_data;
    end
  end

endmodule

// File: rtl/dsp_w_order_dispatcher.sv
// W-channel dispatcher: routes master W bursts to slave lanes in AW order,
// sinking bursts whose AW decoded to no slave and flagging their completion.
module dsp_w_order_dispatcher
  import dsp_pkg::*;
#(
  parameter int SLV_AMT     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTST_DEPTH = OUTST_DEPTH_DEF,
  parameter int SLV_ID_W    = $clog2(SLV_AMT)
) (
  input  logic                           ACLK_i,
  input  logic                           ARESET_i,
  input  logic [SLV_ID_W-1:0]            dsp_AW_slv_id_i,
  input  logic                           dsp_AW_decerr_i,
  input  logic                           dsp_AW_push_i,
  output logic                           dsp_AW_ready_o,
  input  logic [DATA_WIDTH-1:0]          m_WDATA_i,
  input  logic [DATA_WIDTH/8-1:0]        m_WSTRB_i,
  input  logic                           m_WLAST_i,
  input  logic                           m_WVALID_i,
  output logic                           m_WREADY_o,
  output logic [DATA_WIDTH*SLV_AMT-1:0]  sa_WDATA_o,
  output logic [DATA_WIDTH/8*SLV_AMT-1:0] sa_WSTRB_o,
  output logic [SLV_AMT-1:0]             sa_WLAST_o,
  output logic [SLV_AMT-1:0]             sa_WVALID_o,
  input  logic [SLV_AMT-1:0]             sa_WREADY_i,
  output logic                           dsp_B_decerr_o,
  output logic [cnt_w(OUTST_DEPTH)-1:0]  outst_cnt_o
);

  localparam int EW  = ent_w(SLV_ID_W);
  localparam int DB  = ent_decerr_bit(SLV_ID_W);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int PLW = SLV_ID_W + DATA_WIDTH + SW + 1;

  logic [1:0]            r_state;
  logic [SLV_ID_W-1:0]   r_head_id;
  logic                  r_b_decerr;

  logic                  w_full;
  logic                  w_empty_nxt;
  logic [EW-1:0]         w_head_nxt;
  logic                  w_fwd;
  logic                  w_sink;
  logic                  w_skid_rdy;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_out_v;
  logic                  w_out_rdy;
  logic [PLW-1:0]        w_out_pl;
  logic [SLV_ID_W-1:0]   w_out_tag;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [SW-1:0]         w_out_strb;
  logic                  w_out_last;

  assign dsp_AW_ready_o = ~w_full & ~ARESET_i;
  assign w_fwd  = (r_state == ST_FWD);
  assign w_sink = (r_state == ST_SINK);
  assign m_WREADY_o = (w_fwd & w_skid_rdy) | w_sink;
  assign w_acc  = m_WVALID_i & m_WREADY_o;
  assign w_pop  = w_acc & m_WLAST_i;
  assign dsp_B_decerr_o = r_b_decerr;

  dsp_order_fifo #(
    .DEPTH (OUTST_DEPTH),
    .EW    (EW)
  ) u_order_fifo (
    .i_clk       (ACLK_i),
    .i_rst       (ARESET_i),
    .i_push      (dsp_AW_push_i & dsp_AW_ready_o),
    .i_data      ({dsp_AW_decerr_i, dsp_AW_slv_id_i}),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_cnt       (outst_cnt_o),
    .o_empty_nxt (w_empty_nxt),
    .o_head_nxt  (w_head_nxt)
  );

  // Head selection: state and target follow the post-push/pop queue head, so
  // the next burst is served the cycle after a WLAST with no bubble.
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_state   <= ST_IDLE;
      r_head_id <= '0;
    end else begin
      if (w_empty_nxt)          r_state <= ST_IDLE;
      else if (w_head_nxt[DB])  r_state <= ST_SINK;
      else                      r_state <= ST_FWD;
      r_head_id <= w_head_nxt[SLV_ID_W-1:0];
    end
  end

  // One-cycle pulse after the last beat of a sunk burst is accepted
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) r_b_decerr <= 1'b0;
    else          r_b_decerr <= w_pop & w_sink;
  end

  skid_buffer #(
    .W (PLW)
  ) u_skid (
    .i_clk   (ACLK_i),
    .i_rst   (ARESET_i),
    .i_valid (m_WVALID_i & w_fwd),
    .o_ready (w_skid_rdy),
    .i_data  ({r_head_id, m_WDATA_i, m_WSTRB_i, m_WLAST_i}),
    .o_valid (w_out_v),
    .i_ready (w_out_rdy),
    .o_data  (w_out_pl)
  );

  assign {w_out_tag, w_out_data, w_out_strb, w_out_last} = w_out_pl;

  // Ready of the lane the current output beat is tagged for
  always_comb begin
    w_out_rdy = 1'b0;
    for (int i = 0; i < SLV_AMT; i++)
      if (w_out_tag == SLV_ID_W'(i)) w_out_rdy = sa_WREADY_i[i];
  end

  // Payload broadcast to all lanes; only the tagged lane sees valid
  for (genvar g = 0; g < SLV_AMT; g++) begin : g_lane
    assign sa_WVALID_o[g]                   = w_out_v & (w_out_tag == SLV_ID_W'(g));
    assign sa_WLAST_o[g]                    = w_out_last;
    assign sa_WDATA_o[g*DATA_WIDTH +: DATA_WIDTH] = w_out_data;
    assign sa_WSTRB_o[g*SW +: SW]           = w_out_strb;
  end

endmodule

// File: tb/tb_dsp_w_order_dispatcher.sv
// Directed bench for the W-order dispatcher with default parameters.
module tb_dsp_w_order_dispatcher;

  localparam int SA = 4;
  localparam int DW = 32;

  logic          ACLK_i = 1'b0;
  logic          ARESET_i = 1'b1;
  logic [1:0]    dsp_AW_slv_id_i = '0;
  logic          dsp_AW_decerr_i = 1'b0;
  logic          dsp_AW_push_i = 1'b0;
  logic          dsp_AW_ready_o;
  logic [DW-1:0] m_WDATA_i = '0;
  logic [3:0]    m_WSTRB_i = '0;
  logic          m_WLAST_i = 1'b0;
  logic          m_WVALID_i = 1'b0;
  logic          m_WREADY_o;
  logic [DW*SA-1:0] sa_WDATA_o;
  logic [4*SA-1:0]  sa_WSTRB_o;
  logic [SA-1:0] sa_WLAST_o;
  logic [SA-1:0] sa_WVALID_o;
  logic [SA-1:0] sa_WREADY_i = '1;
  logic          dsp_B_decerr_o;
  logic [2:0]    outst_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  dsp_w_order_dispatcher dut (
    .ACLK_i          (ACLK_i),
    .ARESET_i        (ARESET_i),
    .dsp_AW_slv_id_i (dsp_AW_slv_id_i),
    .dsp_AW_decerr_i (dsp_AW_decerr_i),
    .dsp_AW_push_i   (dsp_AW_push_i),
    .dsp_AW_ready_o  (dsp_AW_ready_o),
    .m_WDATA_i       (m_WDATA_i),
    .m_WSTRB_i       (m_WSTRB_i),
    .m_WLAST_i       (m_WLAST_i),
    .m_WVALID_i      (m_WVALID_i),
    .m_WREADY_o      (m_WREADY_o),
    .sa_WDATA_o      (sa_WDATA_o),
    .sa_WSTRB_o      (sa_WSTRB_o),
    .sa_WLAST_o      (sa_WLAST_o),
    .sa_WVALID_o     (sa_WVALID_o),
    .sa_WREADY_i     (sa_WREADY_i),
    .dsp_B_decerr_o  (dsp_B_decerr_o),
    .outst_cnt_o     (outst_cnt_o)
  );

  always #5 ACLK_i = ~ACLK_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK_i);
  endtask

  task automatic wbeat(input logic v, input logic [31:0] d, input logic l);
    m_WVALID_i = v;
    m_WDATA_i  = d;
    m_WSTRB_i  = 4'hF;
    m_WLAST_i  = l;
  endtask

  task automatic aw(input logic p, input logic [1:0] id, input logic de);
    dsp_AW_push_i   = p;
    dsp_AW_slv_id_i = id;
    dsp_AW_decerr_i = de;
  endtask

  function automatic logic [31:0] ldat(input int l);
    return sa_WDATA_o[l*DW +: DW];
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_valid"}, 32'(sa_WVALID_o), 32'h0);
    chk({pfx, "_wdata"}, 32'(|sa_WDATA_o), 32'h0);
    chk({pfx, "_wlast"}, 32'(sa_WLAST_o), 32'h0);
    chk({pfx, "_wready"}, 32'(m_WREADY_o), 32'h0);
    chk({pfx, "_awready"}, 32'(dsp_AW_ready_o), 32'h0);
    chk({pfx, "_cnt"}, 32'(outst_cnt_o), 32'h0);
    chk({pfx, "_decerr"}, 32'(dsp_B_decerr_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sent;
    int rcv;
    logic acc;

    // Reset state
    nxt(); nxt();
    smp();
    chk_all_zero("rst");
    nxt();
    ARESET_i = 1'b0;

    // Single 4-beat burst to slave 2
    aw(1'b1, 2'd2, 1'b0);
    smp();
    chk("t1_awready", 32'(dsp_AW_ready_o), 32'h1);
    chk("t1_idle_wready", 32'(m_WREADY_o), 32'h0);
    nxt();
    aw(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wbeat(i < 4, 32'hA0 + 32'(i), i == 3);
      smp();
      if (i > 0) begin
        chk("t1_valid", 32'(sa_WVALID_o), 32'h4);
        chk("t1_data", ldat(2), 32'hA0 + 32'(i - 1));
        chk("t1_last", 32'(sa_WLAST_o[2]), 32'(i == 4));
      end
      if (i < 4) chk("t1_wready", 32'(m_WREADY_o), 32'h1);
      chk("t1_cnt", 32'(outst_cnt_o), (i == 4) ? 32'h0 : 32'h1);
      nxt();
    end
    wbeat(1'b0, 32'h0, 1'b0);
    smp();
    chk("t1_done_valid", 32'(sa_WVALID_o), 32'h0);
    nxt();

    // Back-to-back 2-beat bursts to slaves 1 then 3
    aw(1'b1, 2'd1, 1'b0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) aw(1'b1, 2'd3, 1'b0);
      else        aw(1'b0, 2'd0, 1'b0);
      wbeat(i < 4, 32'hB0 + 32'(i), (i == 1) || (i == 3));
      smp();
      if (i < 4) chk("t2_wready", 32'(m_WREADY_o), 32'h1);
      if (i > 0) begin
        chk("t2_valid", 32'(sa_WVALID_o), (i <= 2) ? 32'h2 : 32'h8);
        chk("t2_data", ldat((i <= 2) ? 1 : 3), 32'hB0 + 32'(i - 1));
      end
      nxt();
    end
    wbeat(1'b0, 32'h0, 1'b0);

    // Decode-error burst of 3 beats is sunk
    aw(1'b1, 2'd0, 1'b1);
    nxt();
    aw(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wbeat(i < 3, 32'hD0 + 32'(i), i == 2);
      smp();
      if (i < 3) chk("t3_wready", 32'(m_WREADY_o), 32'h1);
      chk("t3_valid", 32'(sa_WVALID_o), 32'h0);
      chk("t3_decerr", 32'(dsp_B_decerr_o), 32'(i == 3));
      nxt();
    end

    // W arrives before any AW: stalled
    wbeat(1'b1, 32'hEE, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t4_early_wready", 32'(m_WREADY_o), 32'h0);
      nxt();
    end
    aw(1'b1, 2'd0, 1'b0);
    smp();
    chk("t4_push_wready", 32'(m_WREADY_o), 32'h0);
    nxt();
    aw(1'b0, 2'd0, 1'b0);

    // Lane 0 back-pressure for 3 cycles in the middle of a 4-beat burst
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 12; c++) begin
      sa_WREADY_i = (c >= 3 && c <= 5) ? 4'b1110 : 4'b1111;
      wbeat(sent < 4, 32'hC0 + 32'(sent), sent == 3);
      smp();
      acc = m_WVALID_i & m_WREADY_o;
      chk("t4_onehot", 32'(sa_WVALID_o & 4'b1110), 32'h0);
      if (sa_WVALID_o[0]) begin
        chk("t4_data", ldat(0), 32'hC0 + 32'(rcv));
        chk("t4_last", 32'(sa_WLAST_o[0]), 32'(rcv == 3));
        if (sa_WREADY_i[0]) rcv++;
      end
      nxt();
      if (acc) sent++;
    end
    chk("t4_beats_rcvd", 32'(rcv), 32'h4);
    sa_WREADY_i = '1;
    wbeat(1'b0, 32'h0, 1'b0);

    // Fill the queue, overflow push ignored
    for (int k = 0; k < 4; k++) begin
      aw(1'b1, 2'd1, 1'b0);
      nxt();
    end
    aw(1'b1, 2'd2, 1'b0);
    smp();
    chk("t5_full_awready", 32'(dsp_AW_ready_o), 32'h0);
    chk("t5_full_cnt", 32'(outst_cnt_o), 32'h4);
    nxt();
    aw(1'b0, 2'd0, 1'b0);
    smp();
    chk("t5_ovf_cnt", 32'(outst_cnt_o), 32'h4);
    nxt();
    // Single-beat pop: 4 -> 3
    wbeat(1'b1, 32'hF0, 1'b1);
    smp();
    chk("t5_pop_wready", 32'(m_WREADY_o), 32'h1);
    nxt();
    // Pop together with push: count stays at 3
    wbeat(1'b1, 32'hF1, 1'b1);
    aw(1'b1, 2'd2, 1'b0);
    smp();
    chk("t5_pop_cnt", 32'(outst_cnt_o), 32'h3);
    chk("t5_awready", 32'(dsp_AW_ready_o), 32'h1);
    nxt();
    aw(1'b0, 2'd0, 1'b0);
    wbeat(1'b0, 32'h0, 1'b0);
    smp();
    chk("t5_pushpop_cnt", 32'(outst_cnt_o), 32'h3);
    chk("t5_valid", 32'(sa_WVALID_o), 32'h2);
    chk("t5_data", ldat(1), 32'hF1);
    nxt();

    // Reset asserted during beat 2 of a 4-beat burst
    wbeat(1'b1, 32'h90, 1'b0);
    smp();
    chk("t6_wready", 32'(m_WREADY_o), 32'h1);
    nxt();
    wbeat(1'b1, 32'h91, 1'b0);
    smp();
    chk("t6_pre_valid", 32'(sa_WVALID_o), 32'h2);
    nxt();
    wbeat(1'b1, 32'h92, 1'b0);
    ARESET_i = 1'b1;
    smp();
    chk_all_zero("t6_rst");
    nxt();
    ARESET_i = 1'b0;
    wbeat(1'b1, 32'h93, 1'b0);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t6_post_valid", 32'(sa_WVALID_o), 32'h0);
      chk("t6_post_wready", 32'(m_WREADY_o), 32'h0);
      chk("t6_post_cnt", 32'(outst_cnt_o), 32'h0);
      nxt();
    end
    wbeat(1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
